// File: rtl/ot_rsa_engine.sv
// RSA oblivious-transfer arithmetic engine: receiver blind (x + k^e mod N) or sender unblind ((v - x)^d mod N).
// Exponentiation is LSB-first square-and-multiply built from two interleaved shift-add modular multipliers.
module ot_rsa_engine #(
    parameter int WIDTH   = 32,
    parameter int NUM_MSG = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [$clog2(NUM_MSG)-1:0]  sel,
    input  logic [NUM_MSG*WIDTH-1:0]    rand_flat,
    input  logic [WIDTH-1:0]            modulus,
    input  logic [WIDTH-1:0]            exponent,
    input  logic [WIDTH-1:0]            operand,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [WIDTH-1:0]            result
);

    localparam int SELW = $clog2(NUM_MSG);
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, CHECK, PRE, EXP, POST, DONE} state_t;

    state_t            state_q;
    logic              mode_q;
    logic              selBad_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  n_q;
    logic [WIDTH-1:0]  op_q;
    logic [WIDTH-1:0]  ebits_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  base_q;
    logic [WIDTH-1:0]  t1_q;
    logic [WIDTH-1:0]  t2_q;
    logic [CW-1:0]     stepCnt_q;
    logic [CW-1:0]     bitCnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [WIDTH-1:0]  result_q;

    logic [WIDTH-1:0]  xSel;
    logic              selOk;
    logic              mulBit;
    logic              inputBad;
    logic [WIDTH-1:0]  t1_d;
    logic [WIDTH-1:0]  t2_d;

    // One step of an MSB-first interleaved modmul; inputs are < n so nothing reaches 2n.
    function automatic logic [WIDTH-1:0] mmStep(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] a,
                                                input logic             b,
                                                input logic [WIDTH-1:0] n);
        logic [WIDTH:0] s;
        logic [WIDTH:0] nn;
        nn = {1'b0, n};
        s  = {t, 1'b0};
        if (s >= nn) s = s - nn;
        if (b) begin
            s = s + {1'b0, a};
            if (s >= nn) s = s - nn;
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] modAdd(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) s = s - {1'b0, n};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] modSub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
        logic [WIDTH:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + {1'b0, n};
        return s[WIDTH-1:0];
    endfunction

    always_comb begin
        xSel  = '0;
        selOk = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (sel == SELW'(i)) begin
                xSel  = rand_flat[i*WIDTH +: WIDTH];
                selOk = 1'b1;
            end
        end
    end

    // Both products share the multiplier operand (base), so one bit feeds both datapaths.
    always_comb begin
        mulBit   = base_q[stepCnt_q];
        t1_d     = mmStep(t1_q, acc_q, mulBit, n_q);
        t2_d     = mmStep(t2_q, base_q, mulBit, n_q);
        inputBad = (n_q < WIDTH'(2)) || selBad_q || (x_q >= n_q) || (op_q >= n_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            selBad_q  <= 1'b0;
            x_q       <= '0;
            n_q       <= '0;
            op_q      <= '0;
            ebits_q   <= '0;
            acc_q     <= '0;
            base_q    <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            stepCnt_q <= '0;
            bitCnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        selBad_q <= ~selOk;
                        x_q      <= xSel;
                        n_q      <= modulus;
                        op_q     <= operand;
                        ebits_q  <= exponent;
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (inputBad) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    base_q    <= mode_q ? modSub(op_q, x_q, n_q) : op_q;
                    acc_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
                    t1_q      <= '0;
                    t2_q      <= '0;
                    stepCnt_q <= CW'(WIDTH-1);
                    bitCnt_q  <= '0;
                    state_q   <= EXP;
                end
                // Fixed WIDTH x WIDTH cycles regardless of exponent value.
                EXP: begin
                    if (stepCnt_q == '0) begin
                        if (ebits_q[0]) acc_q <= t1_d;
                        base_q    <= t2_d;
                        ebits_q   <= ebits_q >> 1;
                        t1_q      <= '0;
                        t2_q      <= '0;
                        stepCnt_q <= CW'(WIDTH-1);
                        bitCnt_q  <= bitCnt_q + 1'b1;
                        if (bitCnt_q == CW'(WIDTH-1)) state_q <= POST;
                    end else begin
                        t1_q      <= t1_d;
                        t2_q      <= t2_d;
                        stepCnt_q <= stepCnt_q - 1'b1;
                    end
                end
                POST: begin
                    result_q <= mode_q ? acc_q : modAdd(acc_q, x_q, n_q);
                    err_q    <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_ot_rsa_engine.sv
// Self-checking bench for ot_rsa_engine: directed OT cases, abort/back-to-back sequencing, and
// randomized jobs compared against a plain-arithmetic modular model.
module tb_ot_rsa_engine;

    localparam int W  = 32;
    localparam int NM = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [1:0]        sel;
    logic [NM*W-1:0]   randFlat;
    logic [W-1:0]      modulus;
    logic [W-1:0]      exponent;
    logic [W-1:0]      operand;
    logic              busy;
    logic              done;
    logic              err;
    logic [W-1:0]      result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acceptCyc = 0;
    int doneOffset = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ot_rsa_engine #(.WIDTH(W), .NUM_MSG(NM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .sel       (sel),
        .rand_flat (randFlat),
        .modulus   (modulus),
        .exponent  (exponent),
        .operand   (operand),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one request; returns at the negedge of the first cycle after the acceptance edge.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [W-1:0] n,
                                 input logic [W-1:0] e, input logic [W-1:0] o, input logic hold);
        @(negedge clk);
        mode = m; sel = s; modulus = n; exponent = e; operand = o; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDone(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                doneOffset = cyc - acceptCyc + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [W-1:0] refPow(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        logic [63:0] r;
        logic [63:0] bb;
        logic [63:0] nn;
        nn = {32'd0, n};
        r  = 64'd1 % nn;
        bb = {32'd0, b} % nn;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * bb) % nn;
            bb = (bb * bb) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] refResult(input logic m, input logic [W-1:0] x, input logic [W-1:0] n,
                                               input logic [W-1:0] e, input logic [W-1:0] o);
        logic [63:0] t;
        if (!m) begin
            t = ({32'd0, x} + {32'd0, refPow(o, e, n)}) % {32'd0, n};
        end else begin
            t = ({32'd0, o} + {32'd0, n} - {32'd0, x}) % {32'd0, n};
            t = {32'd0, refPow(t[W-1:0], e, n)};
        end
        return t[W-1:0];
    endfunction

    task automatic runJob(input string tag, input logic m, input logic [1:0] s, input logic [W-1:0] n,
                          input logic [W-1:0] e, input logic [W-1:0] o,
                          input logic [W-1:0] expRes, input logic expErr);
        logic seen;
        applyStimulus(m, s, n, e, o, 1'b0);
        checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd1);
        waitDone(seen);
        checkOutput({tag, ".doneSeen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput({tag, ".latency"}, 32'(doneOffset), expErr ? 32'd2 : 32'(W*W+4));
            checkOutput({tag, ".result"}, result, expRes);
            checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, expErr});
            @(negedge clk);
            checkOutput({tag, ".donePulse"}, {31'd0, done}, 32'd0);
            checkOutput({tag, ".busyClr"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic seen;
        logic sawDone;
        logic [W-1:0] n, x, o, e, expv;
        logic [1:0] s;
        logic m, expErr;

        rst = 1'b1; start = 1'b0; mode = 1'b0; sel = '0;
        modulus = '0; exponent = '0; operand = '0;
        randFlat = {32'd7, 32'd10, 32'd9};
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.err", {31'd0, err}, 32'd0);
        checkOutput("reset.result", result, 32'd0);
        rst = 1'b0;

        runJob("t1", 1'b0, 2'd1, 33, 3, 5, 32'd3, 1'b0);
        runJob("t2", 1'b1, 2'd1, 33, 7, 3, 32'd5, 1'b0);

        runJob("errN1", 1'b0, 2'd0, 1, 3, 0, 32'd0, 1'b1);
        runJob("errSel", 1'b0, 2'd3, 33, 3, 5, 32'd0, 1'b1);
        randFlat[1*W +: W] = 32'd40;
        runJob("errX", 1'b0, 2'd1, 33, 3, 5, 32'd0, 1'b1);
        randFlat[1*W +: W] = 32'd10;
        runJob("errOp", 1'b0, 2'd1, 33, 3, 33, 32'd0, 1'b1);

        runJob("eqExp0", 1'b1, 2'd0, 33, 0, 9, 32'd1, 1'b0);
        runJob("eqExp5", 1'b1, 2'd0, 33, 5, 9, 32'd0, 1'b0);

        // Maximum legal index with exp=0, plus a start pulse mid-job that must be dropped.
        applyStimulus(1'b0, 2'd2, 33, 0, 4, 1'b0);
        checkOutput("t4.busy", {31'd0, busy}, 32'd1);
        repeat (50) @(negedge clk);
        start = 1'b1; mode = 1'b1; sel = 2'd0; modulus = 1; exponent = 5;
        @(negedge clk);
        start = 1'b0;
        waitDone(seen);
        checkOutput("t4.doneSeen", {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput("t4.latency", 32'(doneOffset), 32'(W*W+4));
            checkOutput("t4.result", result, 32'd8);
            checkOutput("t4.err", {31'd0, err}, 32'd0);
        end
        repeat (3) @(negedge clk);
        checkOutput("t4.notQueuedBusy", {31'd0, busy}, 32'd0);
        checkOutput("t4.notQueuedDone", {31'd0, done}, 32'd0);

        applyStimulus(1'b0, 2'd1, 33, 3, 5, 1'b0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.busy", {31'd0, busy}, 32'd0);
        checkOutput("abort.done", {31'd0, done}, 32'd0);
        checkOutput("abort.err", {31'd0, err}, 32'd0);
        checkOutput("abort.result", result, 32'd0);
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (1100) begin
            @(negedge clk);
            if (done !== 1'b0) sawDone = 1'b1;
        end
        checkOutput("abort.noDone", {31'd0, sawDone}, 32'd0);
        runJob("rerun", 1'b0, 2'd1, 33, 3, 5, 32'd3, 1'b0);

        // start held high: the second job is taken on the edge leaving the IDLE cycle.
        applyStimulus(1'b0, 2'd1, 33, 3, 5, 1'b1);
        checkOutput("b2bA.busy", {31'd0, busy}, 32'd1);
        waitDone(seen);
        checkOutput("b2bA.doneSeen", {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput("b2bA.latency", 32'(doneOffset), 32'(W*W+4));
            checkOutput("b2bA.result", result, 32'd3);
        end
        mode = 1'b1; exponent = 7; operand = 3;
        @(negedge clk);
        checkOutput("b2b.idleBusy", {31'd0, busy}, 32'd0);
        checkOutput("b2b.idleDone", {31'd0, done}, 32'd0);
        checkOutput("b2b.heldResult", result, 32'd3);
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        start = 1'b0;
        checkOutput("b2bB.busy", {31'd0, busy}, 32'd1);
        waitDone(seen);
        checkOutput("b2bB.doneSeen", {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput("b2bB.latency", 32'(doneOffset), 32'(W*W+4));
            checkOutput("b2bB.result", result, 32'd5);
        end
        @(negedge clk);

        for (int j = 0; j < 8; j++) begin
            n = (j < 4) ? 32'($urandom_range(2, 1000)) : $urandom;
            if (n < 2) n = 2;
            s = 2'($urandom_range(0, NM-1));
            randFlat = {$urandom, $urandom, $urandom};
            x = $urandom % n;
            randFlat[int'(s)*W +: W] = x;
            o = (j == 7) ? n : $urandom % n;
            m = 1'($urandom_range(0, 1));
            e = $urandom;
            expErr = (n < 2) || (int'(s) >= NM) || (x >= n) || (o >= n);
            expv = expErr ? '0 : refResult(m, x, n, e, o);
            runJob($sformatf("rand%0d", j), m, s, n, e, o, expv, expErr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
